// File: rtl/alarm_bank_pkg.sv
// Shared definitions for the alarm bank: channel state encoding and a
// width helper used to size the per-channel counters.
package alarm_bank_pkg;

  typedef enum logic [1:0] {
    ALM_IDLE   = 2'd0,
    ALM_RING   = 2'd1,
    ALM_SNOOZE = 2'd2
  } alm_state_e;

  // Number of bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Bus between the alarm bank and its surroundings: the shared seconds
// count, per-channel controls, and per-channel indicator outputs.
interface alarm_bank_if #(
  parameter int N_CH = 4,
  parameter int CW   = 21
);
  logic [CW-1:0]      count;
  logic [N_CH*CW-1:0] alarm_time;
  logic [N_CH-1:0]    alarm_en;
  logic [N_CH-1:0]    stop;
  logic [N_CH-1:0]    snooze;
  logic [N_CH-1:0]    led;
  logic [N_CH-1:0]    ringing;
  logic               any_ring;

  modport master (
    output count, alarm_time, alarm_en, stop, snooze,
    input  led, ringing, any_ring
  );

  modport slave (
    input  count, alarm_time, alarm_en, stop, snooze,
    output led, ringing, any_ring
  );
endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: edge-detected time match, ring/snooze state machine,
// ring and snooze counters, snooze cap and the blinking LED.
module alarm_channel
  import alarm_bank_pkg::*;
#(
  parameter int CW         = 21,
  parameter int RING_LEN   = 60,
  parameter int SNOOZE_LEN = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic          clk_1hz,
  input  logic          rst_n,
  input  logic [CW-1:0] count_i,
  input  logic [CW-1:0] alarm_time_i,
  input  logic          alarm_en_i,
  input  logic          stop_i,
  input  logic          snooze_i,
  output logic          led_o,
  output logic          ringing_o,
  output logic          ringing_next_o
);

  localparam int RING_W = clog2_min1(RING_LEN);
  localparam int SNZ_W  = clog2_min1(SNOOZE_LEN);
  localparam int USED_W = clog2_min1(MAX_SNOOZE + 1);

  localparam logic [RING_W-1:0] RING_RELOAD = RING_W'(RING_LEN - 1);
  localparam logic [RING_W-1:0] RING_ONE    = RING_W'(1);
  localparam logic [RING_W-1:0] RING_ZERO   = {RING_W{1'b0}};
  localparam logic [SNZ_W-1:0]  SNZ_RELOAD  = SNZ_W'(SNOOZE_LEN - 1);
  localparam logic [SNZ_W-1:0]  SNZ_ONE     = SNZ_W'(1);
  localparam logic [SNZ_W-1:0]  SNZ_ZERO    = {SNZ_W{1'b0}};
  localparam logic [USED_W-1:0] USED_CAP    = USED_W'(MAX_SNOOZE);
  localparam logic [USED_W-1:0] USED_ONE    = USED_W'(1);
  localparam logic [USED_W-1:0] USED_ZERO   = {USED_W{1'b0}};

  alm_state_e        state_q, state_d;
  logic              led_q, led_d;
  logic              ringing_q, ringing_d;
  logic              match_q;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [USED_W-1:0] snz_used_q, snz_used_d;
  logic              match_s;
  logic              trigger_s;

  // State, counters, LED and match history advance on each 1 Hz edge.
  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ALM_IDLE;
      led_q      <= 1'b0;
      ringing_q  <= 1'b0;
      match_q    <= 1'b0;
      ring_cnt_q <= RING_ZERO;
      snz_cnt_q  <= SNZ_ZERO;
      snz_used_q <= USED_ZERO;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      ringing_q  <= ringing_d;
      match_q    <= match_s;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      snz_used_q <= snz_used_d;
    end
  end

  // Next state: disable and stop win, then snooze, then trigger/expiry.
  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_used_d = snz_used_q;
    match_s    = alarm_en_i & (count_i == alarm_time_i);
    // Only the rising edge of a match starts a ring, so a held count is quiet.
    trigger_s  = match_s & ~match_q;

    if (!alarm_en_i || stop_i) begin
      state_d    = ALM_IDLE;
      led_d      = 1'b0;
      snz_used_d = USED_ZERO;
    end else begin
      case (state_q)
        ALM_IDLE: begin
          if (trigger_s) begin
            state_d    = ALM_RING;
            led_d      = 1'b1;
            ring_cnt_d = RING_RELOAD;
          end else begin
            led_d = 1'b0;
          end
        end
        ALM_RING: begin
          if (snooze_i) begin
            if (snz_used_q < USED_CAP) begin
              state_d    = ALM_SNOOZE;
              led_d      = 1'b0;
              snz_cnt_d  = SNZ_RELOAD;
              snz_used_d = snz_used_q + USED_ONE;
            end else begin
              // Snooze budget spent: the request behaves as stop.
              state_d    = ALM_IDLE;
              led_d      = 1'b0;
              snz_used_d = USED_ZERO;
            end
          end else if (ring_cnt_q == RING_ZERO) begin
            state_d    = ALM_IDLE;
            led_d      = 1'b0;
            snz_used_d = USED_ZERO;
          end else begin
            ring_cnt_d = ring_cnt_q - RING_ONE;
            led_d      = ~led_q;
          end
        end
        ALM_SNOOZE: begin
          if (snz_cnt_q == SNZ_ZERO) begin
            state_d    = ALM_RING;
            led_d      = 1'b1;
            ring_cnt_d = RING_RELOAD;
          end else begin
            snz_cnt_d = snz_cnt_q - SNZ_ONE;
            led_d     = 1'b0;
          end
        end
        default: begin
          state_d    = ALM_IDLE;
          led_d      = 1'b0;
          snz_used_d = USED_ZERO;
        end
      endcase
    end

    ringing_d = (state_d == ALM_RING);
  end

  assign led_o          = led_q;
  assign ringing_o      = ringing_q;
  assign ringing_next_o = ringing_d;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm engine: N_CH independent channels sharing one
// seconds count, plus a registered "any channel ringing" summary.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CW         = 21,
  parameter int RING_LEN   = 60,
  parameter int SNOOZE_LEN = 300,
  parameter int MAX_SNOOZE = 3
) (
  input logic         clk_1hz,
  input logic         rst_n,
  alarm_bank_if.slave bus
);

  logic [N_CH-1:0] led_s;
  logic [N_CH-1:0] ringing_s;
  logic [N_CH-1:0] ring_next_s;
  logic            any_ring_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    alarm_channel #(
      .CW        (CW),
      .RING_LEN  (RING_LEN),
      .SNOOZE_LEN(SNOOZE_LEN),
      .MAX_SNOOZE(MAX_SNOOZE)
    ) u_ch (
      .clk_1hz       (clk_1hz),
      .rst_n         (rst_n),
      .count_i       (bus.count),
      .alarm_time_i  (bus.alarm_time[g*CW +: CW]),
      .alarm_en_i    (bus.alarm_en[g]),
      .stop_i        (bus.stop[g]),
      .snooze_i      (bus.snooze[g]),
      .led_o         (led_s[g]),
      .ringing_o     (ringing_s[g]),
      .ringing_next_o(ring_next_s[g])
    );
  end

  // Summary flag built from next-state ringing so it lines up with ringing.
  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      any_ring_q <= 1'b0;
    end else begin
      any_ring_q <= |ring_next_s;
    end
  end

  assign bus.led      = led_s;
  assign bus.ringing  = ringing_s;
  assign bus.any_ring = any_ring_q;

endmodule
